spi_crypto_front: RTL and testbench

Parametrised, clock-synchronous SPI target front end for the crypto core. It shifts an MCU-supplied key and plaintext in over SPI, presents them to the core with a one-cycle start pulse, and waits for done. It then captures the cyphertext and shifts it back out MSB first. All SPI pins are oversampled in the system clock domain. The SPI mode (CPOL/CPHA) and all field widths are parameters.

---
 rtl/spi_crypto_pkg.sv | 24 ++
 rtl/spi_pin_sync.sv | 30 +++
 rtl/spi_crypto_front.sv | 154 +++++++++++++++
 tb/tb_spi_crypto_front.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_crypto_pkg.sv
// Shared types for the SPI crypto front end: FSM states, SPI mode and edge selection.
package spi_crypto_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, SHIFT} spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef struct packed {
    logic sample_rise;
    logic shift_rise;
  } edge_sel_t;

  // Modes 0 and 3 sample on the rising edge; modes 1 and 2 sample on the falling edge.
  function automatic edge_sel_t edge_sel(spi_mode_t m);
    edge_sel_t r;
    r.sample_rise = ~(m.cpol ^ m.cpha);
    r.shift_rise  = m.cpol ^ m.cpha;
    return r;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one SPI pin, plus an edge register giving rise/fall pulses.
module spi_pin_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // q is aligned with the edge pulses, so data and clock pins stay in step.
  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_crypto_front.sv
// SPI target front end: shifts key/plaintext in, pulses start, shifts cyphertext out.
// Optional ready output for an MCU interrupt pin when SPI_READY_EN is defined.
module spi_crypto_front
  import spi_crypto_pkg::*;
#(
  parameter int KEY_W = 512,
  parameter int PT_W  = 512,
  parameter int CT_W  = 512,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              sdi,
  input  logic              load,
  output logic              sdo,
  output logic              start,
  input  logic              done,
  output logic [KEY_W-1:0]  key,
  output logic [PT_W-1:0]   plaintext,
  input  logic [CT_W-1:0]   cyphertext,
  output logic              err
`ifdef SPI_READY_EN
  ,
  output logic              ready
`endif
);

  localparam int TOT = KEY_W + PT_W;
  localparam int CW  = $clog2(TOT + 1);
  localparam int SW  = $clog2(CT_W + 1);
  localparam spi_mode_t MODE = '{cpol: CPOL, cpha: CPHA};
  localparam edge_sel_t ES   = edge_sel(MODE);

  // Pin order: [0] sck, [1] sdi, [2] load
  logic [2:0] pins, pin_q, pin_rise, pin_fall;
  assign pins = {load, sdi, sck};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    spi_pin_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pins[i]),
      .q       (pin_q[i]),
      .rise    (pin_rise[i]),
      .fall    (pin_fall[i])
    );
  end

  logic sdi_s, load_rise, load_fall, samp, shft;
  assign sdi_s     = pin_q[1];
  assign load_rise = pin_rise[2];
  assign load_fall = pin_fall[2];
  assign samp      = ES.sample_rise ? pin_rise[0] : pin_fall[0];
  assign shft      = ES.shift_rise  ? pin_rise[0] : pin_fall[0];

  logic unused_pins;
  assign unused_pins = ^{pin_q[0], pin_q[2], pin_rise[1], pin_fall[1]};

  spi_state_e      state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   scnt;
  logic [TOT-1:0]  kp;
  logic [CT_W-1:0] sr;

  assign key       = kp[KEY_W-1:0];
  assign plaintext = kp[TOT-1:KEY_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      scnt  <= '0;
      kp    <= '0;
      sr    <= '0;
      sdo   <= 1'b0;
      start <= 1'b0;
      err   <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (load_rise) begin
            state <= LOAD;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        LOAD: begin
          if (load_fall) begin
            if (cnt == CW'(TOT)) begin
              state <= START;
              start <= 1'b1;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end else if (samp && cnt != CW'(TOT)) begin
            kp  <= {kp[TOT-2:0], sdi_s};
            cnt <= cnt + CW'(1);
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (load_rise) begin
            state <= LOAD;
            cnt   <= '0;
            err   <= 1'b0;
          end else if (done) begin
            state <= SHIFT;
            scnt  <= '0;
            // With CPHA=0 the first sample edge is the leading one, so the MSB goes out now.
            if (!MODE.cpha) begin
              sdo <= cyphertext[CT_W-1];
              sr  <= cyphertext << 1;
            end else begin
              sr  <= cyphertext;
            end
          end
        end
        SHIFT: begin
          if (load_rise) begin
            state <= LOAD;
            cnt   <= '0;
            err   <= 1'b0;
            sdo   <= 1'b0;
          end else if (shft) begin
            sdo <= sr[CT_W-1];
            sr  <= sr << 1;
          end else if (samp) begin
            // The transfer ends once the MCU has sampled the last bit.
            if (scnt == SW'(CT_W - 1)) begin
              sdo   <= 1'b0;
              state <= IDLE;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_READY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready <= 1'b0;
    else if (state == WAIT && done && !load_rise) ready <= 1'b1;
    else if (state != SHIFT || shft || load_rise) ready <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_spi_crypto_front.sv
// Directed bench: 8-bit mode-0 instance driven from a vector table, plus a mode-3 default-width instance.
module tb_spi_crypto_front;
  import spi_crypto_pkg::*;

  localparam int HP = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Mode 0, 8-bit fields
  logic       sck0 = 1'b0, sdi0 = 1'b0, load0 = 1'b0, done0 = 1'b0;
  logic       sdo0, start0, err0;
  logic [7:0] key0, pt0, ct0 = '0;
  // Mode 3, default widths
  logic         sck3 = 1'b1, sdi3 = 1'b0, load3 = 1'b0, done3 = 1'b0;
  logic         sdo3, start3, err3;
  logic [511:0] key3, pt3, ct3 = '0;
`ifdef SPI_READY_EN
  logic rdy0, rdy3;
`endif

  spi_crypto_front #(.KEY_W(8), .PT_W(8), .CT_W(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .sck(sck0), .sdi(sdi0), .load(load0), .sdo(sdo0),
    .start(start0), .done(done0), .key(key0), .plaintext(pt0), .cyphertext(ct0), .err(err0)
`ifdef SPI_READY_EN
    , .ready(rdy0)
`endif
  );

  spi_crypto_front #(.CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clk(clk), .reset_n(reset_n), .sck(sck3), .sdi(sdi3), .load(load3), .sdo(sdo3),
    .start(start3), .done(done3), .key(key3), .plaintext(pt3), .cyphertext(ct3), .err(err3)
`ifdef SPI_READY_EN
    , .ready(rdy3)
`endif
  );

  int total = 0, bad = 0;
  int st0 = 0, st3 = 0;

  always @(negedge clk) begin
    if (start0) st0++;
    if (start3) st3++;
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: data changes while SCK is low, both sides sample on the rising edge.
  task automatic xfer0(input logic b, output logic r);
    sdi0 = b;
    clks(HP);
    sck0 = 1'b1;
    r = sdo0;
    clks(HP);
    sck0 = 1'b0;
  endtask

  // Mode 3: data changes on the falling edge, sampled on the rising edge.
  task automatic xfer3(input logic b, output logic r);
    sck3 = 1'b0;
    sdi3 = b;
    clks(HP);
    sck3 = 1'b1;
    r = sdo3;
    clks(HP);
  endtask

  task automatic send0(input logic [15:0] tx, input int nbits);
    logic r;
    load0 = 1'b1;
    clks(5);
    for (int i = 0; i < nbits; i++) xfer0(tx[15-i], r);
    clks(2);
    load0 = 1'b0;
    clks(8);
  endtask

  task automatic read0(input logic [7:0] ct, output logic [7:0] rx);
    logic r;
    ct0 = ct;
    done0 = 1'b1;
    clks(2);
    for (int i = 0; i < 8; i++) begin
      xfer0(1'b0, r);
      rx[7-i] = r;
    end
    done0 = 1'b0;
    clks(6);
  endtask

  typedef struct {
    logic [15:0] tx;
    logic [7:0]  pt;
    logic [7:0]  key;
    logic [7:0]  ct;
    logic        msb;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0]    rx8;
    logic [2:0]    rx3b;
    logic          r;
    int            s0;
    logic [1023:0] tx3;
    logic [511:0]  rx512;

    vecs[0] = '{tx: 16'hA53C, pt: 8'hA5, key: 8'h3C, ct: 8'h96, msb: 1'b1};
    vecs[1] = '{tx: 16'hFF00, pt: 8'hFF, key: 8'h00, ct: 8'h01, msb: 1'b0};
    vecs[2] = '{tx: 16'h00FF, pt: 8'h00, key: 8'hFF, ct: 8'h80, msb: 1'b1};
    vecs[3] = '{tx: 16'h5AC3, pt: 8'h5A, key: 8'hC3, ct: 8'h6E, msb: 1'b0};

    clks(3);
    chk("rst_key", 512'(key0), 512'h0);
    chk("rst_pt", 512'(pt0), 512'h0);
    chk("rst_sdo", 512'(sdo0), 512'h0);
    chk("rst_err", 512'(err0), 512'h0);
    chk("rst_start", 512'(start0), 512'h0);
    reset_n = 1'b1;
    clks(4);
    chk("idle_state", 512'(dut0.state), 512'(IDLE));

    // Table-driven mode-0 transactions
    for (int v = 0; v < 4; v++) begin
      s0 = st0;
      send0(vecs[v].tx, 16);
      chk($sformatf("v%0d_pt", v), 512'(pt0), 512'(vecs[v].pt));
      chk($sformatf("v%0d_key", v), 512'(key0), 512'(vecs[v].key));
      chk($sformatf("v%0d_start", v), 512'(st0 - s0), 512'd1);
      chk($sformatf("v%0d_err", v), 512'(err0), 512'h0);
      chk($sformatf("v%0d_wait", v), 512'(dut0.state), 512'(WAIT));
      ct0 = vecs[v].ct;
      done0 = 1'b1;
      clks(2);
      chk($sformatf("v%0d_msb_early", v), 512'(sdo0), 512'(vecs[v].msb));
      done0 = 1'b0;
      ct0 = '0;
      clks(1);
      read0(vecs[v].ct, rx8);
      chk($sformatf("v%0d_rd", v), 512'(rx8), 512'(vecs[v].ct));
      chk($sformatf("v%0d_sdo_end", v), 512'(sdo0), 512'h0);
      chk($sformatf("v%0d_idle", v), 512'(dut0.state), 512'(IDLE));
    end

    // Short load: 15 of 16 bits
    s0 = st0;
    send0(16'hFFFE, 15);
    chk("short_err", 512'(err0), 512'h1);
    chk("short_nostart", 512'(st0 - s0), 512'd0);
    chk("short_idle", 512'(dut0.state), 512'(IDLE));
    load0 = 1'b1;
    clks(5);
    chk("reload_err_clr", 512'(err0), 512'h0);
    chk("reload_state", 512'(dut0.state), 512'(LOAD));
    for (int i = 0; i < 16; i++) xfer0(((16'h1234 >> (15 - i)) & 16'h1) != 0, r);
    clks(2);
    load0 = 1'b0;
    clks(8);
    chk("reload_pt", 512'(pt0), 512'h12);
    chk("reload_key", 512'(key0), 512'h34);
    chk("reload_start", 512'(st0 - s0), 512'd1);
    read0(8'hC5, rx8);
    chk("reload_rd", 512'(rx8), 512'hC5);

    // Abort during SHIFT after 3 bits
    send0(16'h7E81, 16);
    ct0 = 8'hF0;
    done0 = 1'b1;
    clks(2);
    for (int i = 0; i < 3; i++) begin
      xfer0(1'b0, r);
      rx3b[2-i] = r;
    end
    done0 = 1'b0;
    chk("abort_3bits", 512'(rx3b), 512'h7);
    chk("abort_in_shift", 512'(dut0.state), 512'(SHIFT));
    load0 = 1'b1;
    clks(5);
    chk("abort_load", 512'(dut0.state), 512'(LOAD));
    chk("abort_cnt", 512'(dut0.cnt), 512'h0);
    chk("abort_sdo", 512'(sdo0), 512'h0);
    s0 = st0;
    for (int i = 0; i < 16; i++) xfer0(((16'h0FF0 >> (15 - i)) & 16'h1) != 0, r);
    clks(2);
    load0 = 1'b0;
    clks(8);
    chk("abort_pt", 512'(pt0), 512'h0F);
    chk("abort_key", 512'(key0), 512'hF0);
    chk("abort_start", 512'(st0 - s0), 512'd1);
    read0(8'h3B, rx8);
    chk("abort_rd", 512'(rx8), 512'h3B);
    chk("abort_idle", 512'(dut0.state), 512'(IDLE));

    // Mode 3, 1024 random bits in, 512 bits out
    for (int w = 0; w < 32; w++) tx3[w*32 +: 32] = $urandom;
    for (int w = 0; w < 16; w++) ct3[w*32 +: 32] = $urandom;
    s0 = st3;
    load3 = 1'b1;
    clks(5);
    for (int i = 0; i < 1024; i++) xfer3(tx3[1023-i], r);
    clks(2);
    load3 = 1'b0;
    clks(8);
    chk("m3_pt", pt3, tx3[1023:512]);
    chk("m3_key", key3, tx3[511:0]);
    chk("m3_start", 512'(st3 - s0), 512'd1);
    chk("m3_err", 512'(err3), 512'h0);
    done3 = 1'b1;
    clks(3);
    for (int i = 0; i < 512; i++) begin
      xfer3(1'b0, r);
      rx512[511-i] = r;
    end
    done3 = 1'b0;
    clks(6);
    chk("m3_rd", rx512, ct3);
    chk("m3_idle", 512'(dut3.state), 512'(IDLE));
    chk("m3_sdo_end", 512'(sdo3), 512'h0);

    // Asynchronous reset while waiting for done
    send0(16'hFFFF, 16);
    chk("wait_before_rst", 512'(dut0.state), 512'(WAIT));
    chk("key_before_rst", 512'(key0), 512'hFF);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_state", 512'(dut0.state), 512'(IDLE));
    chk("arst_key", 512'(key0), 512'h0);
    chk("arst_pt", 512'(pt0), 512'h0);
    chk("arst_sdo", 512'(sdo0), 512'h0);
    chk("arst_start", 512'(start0), 512'h0);
    chk("arst_err", 512'(err0), 512'h0);
    chk("arst_key3", key3, 512'h0);
`ifdef SPI_READY_EN
    chk("arst_ready", 512'(rdy0), 512'h0);
`endif
    clks(2);
    reset_n = 1'b1;
    clks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
